// File: rtl/prog_sequencer.sv
// Program store plus run-control sequencer feeding instruction words to the
// CPU decode stage. Supports single-step, divided-rate run, full-speed run,
// hardware breakpoint, halt-opcode detection, core branches and a timed
// one-word-per-clock ROM clear.
module prog_sequencer #(
  parameter int unsigned       ADDR_W    = 8,
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       RUN_DIV   = 4,
  parameter logic [DATA_W-1:0] HALT_CODE = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rstROM,
  input  logic              edit,
  input  logic [ADDR_W-1:0] unit,
  input  logic [DATA_W-1:0] code,
  input  logic              send,
  input  logic              NEXT,
  input  logic              RUN,
  input  logic              SPEEDRUN,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              busy,
  output logic [ADDR_W-1:0] counter_monitor_signal
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned DIV_W = (RUN_DIV > 2) ? $clog2(RUN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_RUN,
    S_SPEED,
    S_HALT
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   clr_q, clr_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                bypass_q, bypass_d;
  logic                send_q, next_q, speed_q, run_q;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  logic                send_edge, next_edge, speed_edge, run_rise;
  logic                bp_hit, want_issue;
  logic [DATA_W-1:0]   rd_word;

  assign send_edge  = send & ~send_q;
  assign next_edge  = NEXT & ~next_q;
  assign speed_edge = SPEEDRUN & ~speed_q;
  assign run_rise   = RUN & ~run_q;
  assign bp_hit     = bp_en && (pc_q == bp_addr);
  assign rd_word    = mem_q[pc_q];

  // State, pipeline and edge-detector registers; rst wins over everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      clr_q    <= '0;
      div_q    <= '0;
      bypass_q <= 1'b0;
      send_q   <= 1'b0;
      next_q   <= 1'b0;
      speed_q  <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      clr_q    <= clr_d;
      div_q    <= div_d;
      bypass_q <= bypass_d;
      send_q   <= send;
      next_q   <= NEXT;
      speed_q  <= SPEEDRUN;
      run_q    <= RUN;
    end
  end

  // Program memory write port; contents survive reset, but a reset cycle
  // suppresses any write so an interrupted clear stays partial.
  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Next-state, issue and memory-write decisions.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    valid_d    = 1'b0;
    clr_d      = clr_q;
    div_d      = div_q;
    bypass_d   = bypass_q;
    mem_we     = 1'b0;
    mem_waddr  = unit;
    mem_wdata  = code;
    want_issue = 1'b0;

    if (state_q == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_q;
      mem_wdata = '0;
      pc_d      = '0;
      if (clr_q == '1) begin
        state_d = S_IDLE;
      end else begin
        clr_d = clr_q + 1'b1;
      end
    end else if (rstROM) begin
      state_d  = S_CLEAR;
      clr_d    = '0;
      pc_d     = '0;
      div_d    = '0;
      bypass_d = 1'b0;
    end else begin
      if ((state_q == S_IDLE || state_q == S_HALT) && edit && send_edge) begin
        mem_we = 1'b1;
      end

      unique case (state_q)
        S_IDLE: begin
          if (!edit) begin
            if (speed_edge) begin
              state_d = S_SPEED;
            end else if (RUN) begin
              state_d = S_RUN;
              div_d   = '0;
            end else if (next_edge) begin
              want_issue = 1'b1;
            end
          end
        end
        S_RUN: begin
          if (!RUN) begin
            state_d = S_IDLE;
            div_d   = '0;
          end else begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
            if (div_q == '0) begin
              if (!jump_en && bp_hit) begin
                state_d = S_HALT;
              end else begin
                want_issue = 1'b1;
              end
            end
          end
        end
        S_SPEED: begin
          if (!jump_en && bp_hit && !bypass_q) begin
            state_d = S_HALT;
          end else begin
            want_issue = 1'b1;
          end
        end
        S_HALT: begin
          if (!edit) begin
            if (speed_edge) begin
              state_d  = S_SPEED;
              bypass_d = 1'b1;
            end else if (run_rise) begin
              state_d = S_RUN;
              div_d   = '0;
            end else if (next_edge) begin
              want_issue = 1'b1;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase

      // A branch replaces the issue of this cycle; mode changes still apply.
      if (jump_en) begin
        pc_d = jump_addr;
      end else if (want_issue) begin
        instr_d  = rd_word;
        valid_d  = 1'b1;
        pc_d     = pc_q + 1'b1;
        bypass_d = 1'b0;
        if (rd_word == HALT_CODE) begin
          state_d = S_HALT;
        end
      end
    end
  end

  assign instr                  = instr_q;
  assign instr_valid            = valid_q;
  assign pc                     = pc_q;
  assign halted                 = (state_q == S_HALT);
  assign busy                   = (state_q == S_CLEAR);
  assign counter_monitor_signal = pc_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed self-checking bench for prog_sequencer with default parameters.
module tb_prog_sequencer;

  logic       clk = 1'b0;
  logic       rst, rstROM, edit, send, NEXT, RUN, SPEEDRUN, jump_en, bp_en;
  logic [7:0] unit, code, jump_addr, bp_addr;
  logic [7:0] instr, pc, cms;
  logic       instr_valid, halted, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prog_sequencer #(
    .ADDR_W   (8),
    .DATA_W   (8),
    .RUN_DIV  (4),
    .HALT_CODE(8'hFF)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .rstROM                (rstROM),
    .edit                  (edit),
    .unit                  (unit),
    .code                  (code),
    .send                  (send),
    .NEXT                  (NEXT),
    .RUN                   (RUN),
    .SPEEDRUN              (SPEEDRUN),
    .jump_en               (jump_en),
    .jump_addr             (jump_addr),
    .bp_en                 (bp_en),
    .bp_addr               (bp_addr),
    .instr                 (instr),
    .instr_valid           (instr_valid),
    .pc                    (pc),
    .halted                (halted),
    .busy                  (busy),
    .counter_monitor_signal(cms)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    edit = 1'b1; unit = a; code = d; send = 1'b1;
    tick();
    send = 1'b0;
    tick();
    edit = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    jump_en = 1'b1; jump_addr = a;
    tick();
    jump_en = 1'b0; NEXT = 1'b1;
    tick();
    NEXT = 1'b0;
    d = instr;
    tick();
  endtask

  task automatic pulse_rst();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         n;
    logic [11:0] v;
    logic [7:0]  d;

    rst = 1'b0; rstROM = 1'b0; edit = 1'b0; unit = '0; code = '0; send = 1'b0;
    NEXT = 1'b0; RUN = 1'b0; SPEEDRUN = 1'b0; jump_en = 1'b0; jump_addr = '0;
    bp_en = 1'b0; bp_addr = '0;
    tick();
    chk("rst_pc",     32'(pc), 0);
    chk("rst_valid",  32'(instr_valid), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_busy",   32'(busy), 0);
    chk("rst_instr",  32'(instr), 0);
    rst = 1'b1;

    // full clear: busy for exactly 256 clocks
    rstROM = 1'b1; tick(); rstROM = 1'b0;
    n = 0;
    while (busy && n < 300) begin n++; tick(); end
    chk("clear_len", 32'(n), 256);
    chk("clear_pc",  32'(pc), 0);

    // speedrun over the whole ROM
    wr(8'd1, 8'h10);
    wr(8'd2, 8'h30);
    SPEEDRUN = 1'b1; tick(); SPEEDRUN = 1'b0;
    chk("speed_entry_valid", 32'(instr_valid), 0);
    n = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (instr_valid) n++;
      if (i == 1)   chk("speed_issue2", 32'(instr), 32'h10);
      if (i == 2)   chk("speed_issue3", 32'(instr), 32'h30);
      if (i == 254) chk("speed_pc255", 32'(pc), 255);
      if (i == 255) chk("speed_pc_wrap", 32'(pc), 0);
    end
    chk("speed_strobes", 32'(n), 256);
    chk("monitor_mirror", 32'(cms), 32'(pc));
    pulse_rst();
    chk("rst2_valid", 32'(instr_valid), 0);
    chk("rst2_pc",    32'(pc), 0);

    // RUN at divide-by-4
    RUN = 1'b1;
    v = '0;
    for (int i = 0; i < 12; i++) begin tick(); v[i] = instr_valid; end
    chk("run_pattern", 32'(v), 32'h222);
    chk("run_pc",      32'(pc), 3);
    RUN = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (instr_valid) n++; end
    chk("run_stop_strobes", 32'(n), 0);
    chk("run_stop_pc",      32'(pc), 3);
    chk("instr_hold",       32'(instr), 32'h30);
    pulse_rst();

    // breakpoint at 2
    bp_en = 1'b1; bp_addr = 8'd2;
    SPEEDRUN = 1'b1; tick(); SPEEDRUN = 1'b0;
    tick();
    chk("bp_issue0_pc", 32'(pc), 1);
    tick();
    chk("bp_issue1_instr", 32'(instr), 32'h10);
    tick();
    chk("bp_halted", 32'(halted), 1);
    chk("bp_pc",     32'(pc), 2);
    chk("bp_valid",  32'(instr_valid), 0);
    tick();
    chk("bp_hold_valid", 32'(instr_valid), 0);
    NEXT = 1'b1; tick(); NEXT = 1'b0;
    chk("bp_step_instr",  32'(instr), 32'h30);
    chk("bp_step_valid",  32'(instr_valid), 1);
    chk("bp_step_pc",     32'(pc), 3);
    chk("bp_step_halted", 32'(halted), 1);

    // halt opcode at 3
    wr(8'd3, 8'hFF);
    SPEEDRUN = 1'b1; tick(); SPEEDRUN = 1'b0;
    chk("resume_not_halted", 32'(halted), 0);
    tick();
    chk("hc_instr", 32'(instr), 32'hFF);
    chk("hc_valid", 32'(instr_valid), 1);
    chk("hc_pc",    32'(pc), 4);
    tick();
    chk("hc_halted", 32'(halted), 1);
    n = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (instr_valid) n++; end
    chk("hc_no_strobes", 32'(n), 0);
    chk("hc_pc_frozen",  32'(pc), 4);
    bp_en = 1'b0;
    pulse_rst();
    chk("rst3_halted", 32'(halted), 0);

    // jump during SPEED
    wr(8'h80, 8'h5A);
    SPEEDRUN = 1'b1; tick(); SPEEDRUN = 1'b0;
    tick();
    chk("jmp_pre_pc", 32'(pc), 1);
    jump_en = 1'b1; jump_addr = 8'h80; tick(); jump_en = 1'b0;
    chk("jmp_pc",       32'(pc), 32'h80);
    chk("jmp_nostrobe", 32'(instr_valid), 0);
    tick();
    chk("jmp_instr", 32'(instr), 32'h5A);
    chk("jmp_valid", 32'(instr_valid), 1);
    chk("jmp_next_pc", 32'(pc), 32'h81);
    pulse_rst();

    // full clear wipes written words
    rstROM = 1'b1; tick(); rstROM = 1'b0;
    n = 0;
    while (busy && n < 300) begin n++; tick(); end
    chk("clear2_len", 32'(n), 256);
    rd(8'd1, d);    chk("clr_mem1",  32'(d), 0);
    rd(8'd3, d);    chk("clr_mem3",  32'(d), 0);
    rd(8'h80, d);   chk("clr_mem80", 32'(d), 0);

    // clear interrupted by rst at its 100th address
    wr(8'd99,  8'h63);
    wr(8'd100, 8'h64);
    wr(8'd200, 8'hC8);
    rstROM = 1'b1; tick(); rstROM = 1'b0;
    chk("pclr_busy0", 32'(busy), 1);
    repeat (100) tick();
    chk("pclr_busy100", 32'(busy), 1);
    rst = 1'b0; tick(); rst = 1'b1;
    chk("pclr_busy_off", 32'(busy), 0);
    chk("pclr_halted",   32'(halted), 0);
    chk("pclr_pc",       32'(pc), 0);
    rd(8'd99, d);   chk("pclr_mem99",  32'(d), 0);
    rd(8'd100, d);  chk("pclr_mem100", 32'(d), 32'h64);
    rd(8'd200, d);  chk("pclr_mem200", 32'(d), 32'hC8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
- Parametrised program store plus run-control sequencer feeding instruction words to the CPU datapath.
- Generalises the fixed 8-bit step/run/speedrun front end:
  - configurable address and word widths;
  - programmable run-rate divider;
  - hardware breakpoint;
  - halt-opcode detection;
  - timed ROM-clear FSM.
- Sits between the board controls (edit/unit/code/send, NEXT/RUN/SPEEDRUN) and the CPU core's decode stage.

Parameters:
- ADDR_W, 8, program address width; depth = 2**ADDR_W.
- DATA_W, 8, instruction word width.
- RUN_DIV, 4, clocks per issued instruction in RUN mode (>=2).
- HALT_CODE, all-ones of DATA_W, opcode that halts the sequencer once issued.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- rstROM  in  1  synchronous request to zero program memory.
- edit  in  1  program-edit enable.
- unit  in  ADDR_W  edit write address.
- code  in  DATA_W  edit write data.
- send  in  1  edit write strobe, rising-edge detected.
- NEXT  in  1  single-step request, rising-edge detected.
- RUN  in  1  level: free-run at divided rate while high.
- SPEEDRUN  in  1  rising edge: run at one instruction/clock until halt.
- jump_en  in  1  core branch request.
- jump_addr  in  ADDR_W  branch target.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  ADDR_W  breakpoint address.
- instr  out  DATA_W  issued instruction word.
- instr_valid  out  1  one-cycle strobe qualifying instr.
- pc  out  ADDR_W  address of next instruction to issue.
- halted  out  1  sequencer in HALT.
- busy  out  1  ROM clear in progress.
- counter_monitor_signal  out  ADDR_W  mirror of pc for board display.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state IDLE; pc=0, instr=0, instr_valid=0, halted=0, busy=0.
  - Edge detectors cleared; divider=0.
  - Memory contents untouched.
  - rst has priority over every other input, including an in-progress clear; a partially cleared ROM stays partially cleared.
- States: CLEAR, IDLE, RUN, SPEED, HALT.
- Edges: send/NEXT/SPEEDRUN edges are detected against the previous-cycle sample; a held-high level never retriggers.
- CLEAR:
  - Entered from any state when rstROM=1.
  - Writes 0 to addresses 0..2**ADDR_W-1, one per clock; busy=1 throughout; pc=0; no issue.
  - After the last address, goes to IDLE with busy=0.
  - rstROM held high restarts the clear at address 0 each cycle it is sampled high after completion.
- Edit:
  - send edge with edit=1 in IDLE or HALT writes code to mem[unit] that cycle.
  - Ignored in CLEAR/RUN/SPEED.
  - edit=1 also blocks NEXT/RUN/SPEEDRUN.
- Issue: an issue at cycle t gives, at t+1:
  - instr = mem[pc(t)], instr_valid=1;
  - pc = pc(t)+1, modulo 2**ADDR_W (wrap to 0).
- IDLE:
  - NEXT edge -> one issue, stay IDLE.
  - RUN=1 -> RUN.
  - SPEEDRUN edge -> SPEED.
- RUN:
  - Divider counts 0..RUN_DIV-1; issue when divider==0. The first issue is on the first cycle in RUN.
  - RUN=0 -> IDLE, divider reset.
- SPEED: issue every clock.
- Breakpoint:
  - In RUN/SPEED, if bp_en and pc==bp_addr on a would-be issue cycle, no issue; go to HALT.
  - In HALT, a NEXT edge issues exactly one instruction ignoring the breakpoint and stays in HALT.
  - SPEEDRUN edge resumes SPEED with a one-issue breakpoint bypass.
  - RUN resume requires RUN to go 0 then 1.
- Halt opcode: any issue whose word equals HALT_CODE enters HALT after the issue (the word is still presented with instr_valid=1).
- halted=1 exactly while in HALT. HALT -> IDLE on rst only, or via CLEAR.
- Jump:
  - jump_en=1 in any non-CLEAR state loads pc=jump_addr next cycle and suppresses the issue in that cycle.
  - Takes precedence over breakpoint evaluation that cycle.
- Simultaneous NEXT edge and SPEEDRUN edge in IDLE: SPEEDRUN wins.
- instr holds its last value when instr_valid=0.

Test Plan:
- rst low 1 clk; write 8'h10@1, 8'h30@2 via edit/send; SPEEDRUN edge -> instr_valid on 256 consecutive clks; 8'h10 then 8'h30 at issues 2 and 3; pc wraps 255->0.
- RUN held high, RUN_DIV=4 -> instr_valid once every 4 clks; RUN low -> IDLE, no further strobes, pc frozen.
- bp_en=1, bp_addr=2, SPEEDRUN -> issues pc 0,1 then halted=1, pc=2; NEXT edge -> instr=mem[2], pc=3, still halted.
- mem[3]=8'hFF, SPEEDRUN -> 8'hFF presented with instr_valid, then halted=1, pc=4, no further strobes.
- jump_en with jump_addr=8'h80 during SPEED -> next cycle pc=0x80, no strobe that cycle; following issue is mem[0x80].
- rstROM pulse -> busy=1 for exactly 256 clks, all words read 0 afterward; rst low at clk 100 of clear -> busy=0, state IDLE, addresses >=100 retain old data.
